// File: rtl/alu_sequencer.sv
// alu_sequencer: takes one decoded command per request handshake, drives the accumulator ALU
// strobes in order and returns the result. Defining ALU_SEQ_PRESERVE_EN enables ACC save/restore.
module alu_sequencer #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [4:0]       req_op,
    input  logic [7:0]       req_operand,
    input  logic             req_preserve,
    output logic [4:0]       alu_opcode,
    output logic [7:0]       alu_data,
    output logic             alu_ctrl_sig,
    output logic             alu_tmp_write_en,
    output logic             alu_acc_write_en,
    output logic             alu_flags_write_en,
    output logic             alu_act_store,
    output logic             alu_act_restore,
    input  logic [7:0]       alu_out,
    input  logic [3:0]       alu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_err,
    output logic [CNT_W-1:0] stat_ops,
    output logic [ERR_W-1:0] stat_errs
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both 1.
    // req_ready is 1 only in IDLE; resp_valid is 1 only in RESP and the payload holds until resp_ready.

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EXEC, S_WRITE, S_SETTLE, S_RESTORE, S_RESP
    } state_t;

    localparam logic [1:0] CMD_ALU = 2'b00;
    localparam logic [1:0] CMD_LDA = 2'b01;
    localparam logic [1:0] CMD_LDF = 2'b10;
    localparam logic [1:0] CMD_BAD = 2'b11;
    localparam logic [4:0] OP_CMP  = 5'b00111;
    localparam logic [4:0] OP_DAA  = 5'b01100;
    localparam logic [4:0] OP_LAST = 5'b10001;

    state_t           state_q, state_d;
    logic [1:0]       cmd_q;
    logic [4:0]       op_q;
    logic [7:0]       operand_q;
    logic             err_q;
    logic [7:0]       result_q;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] ops_q;
    logic [ERR_W-1:0] errs_q;

    logic accept;
    logic req_alu;
    logic req_binary;
    logic req_pres;
    logic req_illegal;

`ifdef ALU_SEQ_PRESERVE_EN
    logic pres_q;
    logic binary_q;
`else
    logic unused_preserve;
    assign unused_preserve = req_preserve;
`endif

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        req_alu    = (req_cmd == CMD_ALU);
        req_binary = (req_op <= OP_CMP);
`ifdef ALU_SEQ_PRESERVE_EN
        req_pres   = req_alu && req_preserve;
`else
        req_pres   = 1'b0;
`endif
        // CMP with preserve is rejected: the saved ACC slot is where CMP leaves its result.
        req_illegal = (req_cmd == CMD_BAD)
                   || (req_alu && ((req_op == OP_DAA) || (req_op > OP_LAST)))
                   || (req_pres && (req_op == OP_CMP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= 2'b00;
            op_q      <= 5'b00000;
            operand_q <= 8'h00;
            err_q     <= 1'b0;
            result_q  <= 8'h00;
            flags_q   <= 4'h0;
            ops_q     <= '0;
            errs_q    <= '0;
`ifdef ALU_SEQ_PRESERVE_EN
            pres_q    <= 1'b0;
            binary_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q     <= req_cmd;
                op_q      <= req_op;
                operand_q <= req_operand;
                err_q     <= req_illegal;
`ifdef ALU_SEQ_PRESERVE_EN
                pres_q    <= req_pres && !req_illegal;
                binary_q  <= req_binary;
`endif
                if (req_illegal) begin
                    result_q <= 8'h00;
                    flags_q  <= 4'h0;
                end
            end
            if (state_q == S_SETTLE) begin
                result_q <= alu_out;
                flags_q  <= alu_flags;
            end
            if ((state_q == S_RESP) && resp_ready) begin
                if (err_q) begin
                    if (errs_q != {ERR_W{1'b1}}) begin
                        errs_q <= errs_q + ERR_W'(1);
                    end
                end else begin
                    ops_q <= ops_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        state_d = S_RESP;
                    end else if (req_alu) begin
                        state_d = req_binary ? S_LOAD : S_EXEC;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_LOAD:    state_d = S_EXEC;
            S_EXEC:    state_d = S_SETTLE;
            S_WRITE:   state_d = S_SETTLE;
`ifdef ALU_SEQ_PRESERVE_EN
            S_SETTLE:  state_d = pres_q ? S_RESTORE : S_RESP;
`else
            S_SETTLE:  state_d = S_RESP;
`endif
            S_RESTORE: state_d = S_RESP;
            S_RESP:    state_d = resp_ready ? S_IDLE : S_RESP;
            default:   state_d = S_IDLE;
        endcase
    end

    // All ALU strobes decode from the registered state, so each lasts exactly one cycle.
    always_comb begin
        req_ready          = (state_q == S_IDLE);
        resp_valid         = (state_q == S_RESP);
        resp_err           = (state_q == S_RESP) && err_q;
        alu_tmp_write_en   = (state_q == S_LOAD);
        alu_ctrl_sig       = (state_q == S_EXEC);
        alu_acc_write_en   = (state_q == S_WRITE) && (cmd_q == CMD_LDA);
        alu_flags_write_en = (state_q == S_WRITE) && (cmd_q == CMD_LDF);
        alu_data           = ((state_q == S_LOAD) || (state_q == S_WRITE)) ? operand_q : 8'h00;
`ifdef ALU_SEQ_PRESERVE_EN
        alu_act_store      = pres_q && ((state_q == S_LOAD) || ((state_q == S_EXEC) && !binary_q));
        alu_act_restore    = (state_q == S_RESTORE);
`else
        alu_act_store      = 1'b0;
        alu_act_restore    = 1'b0;
`endif
    end

    assign alu_opcode  = op_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign stat_ops    = ops_q;
    assign stat_errs   = errs_q;

endmodule
